// File: rtl/alarm_pkg.sv
// Shared alarm types: countdown state encoding, default widths
// and the interval-select codes used by the FSM and parameter store.
package alarm_pkg;

  localparam int VALUE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_ALARM    = 2'd0,
    SEL_SNOOZE   = 2'd1,
    SEL_PREALERT = 2'd2,
    SEL_TIMEOUT  = 2'd3
  } interval_sel_t;

endpackage

// File: rtl/interval_countdown_sec_tick_gen.sv
// Seconds divider: counts clock cycles while enabled and flags
// the last cycle of each second.
module sec_tick_gen #(
  parameter int CYCLES_PER_SEC = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int DW = (CYCLES_PER_SEC > 2) ?
                      $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [DW-1:0] LAST = DW'(CYCLES_PER_SEC - 1);

  logic [DW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Divider rests at zero whenever the countdown is not running
  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (clear || !enable || tick)
      cnt <= '0;
    else
      cnt <= cnt + DW'(1);
  end

endmodule

// File: rtl/interval_countdown.sv
// Interval countdown timer: loads a seconds value on start_timer,
// counts it down on divider ticks and pulses expired when done.
module interval_countdown
  import alarm_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 4,
  parameter int VALUE_W        = VALUE_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_timer,
  input  logic [VALUE_W-1:0] value,
  output logic               expired,
  output logic               running,
  output logic [VALUE_W-1:0] remaining,
  output logic               sec_tick
);

  state_t             state;
  state_t             state_n;
  logic [VALUE_W-1:0] rem_n;
  logic               tick;

  sec_tick_gen #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_div (
    .clock (clock),
    .reset (reset),
    .clear (start_timer),
    .enable(state == RUNNING),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    rem_n   = remaining;
    unique case (state)
      IDLE: begin
        rem_n = remaining;
      end
      RUNNING: begin
        if (tick) begin
          if (remaining > VALUE_W'(1)) begin
            rem_n = remaining - VALUE_W'(1);
          end else begin
            rem_n   = '0;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        rem_n   = '0;
        state_n = IDLE;
      end
      default: begin
        rem_n   = '0;
        state_n = IDLE;
      end
    endcase
    // A load beats any expiry landing in the same cycle
    if (start_timer) begin
      rem_n   = value;
      state_n = (value == '0) ? DONE : RUNNING;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      expired   <= 1'b0;
      running   <= 1'b0;
      sec_tick  <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      expired   <= (state_n == DONE);
      running   <= (state_n == RUNNING);
      sec_tick  <= tick;
    end
  end

endmodule

// File: tb/tb_interval_countdown.sv
// Directed bench for interval_countdown with an expiry-cycle
// scoreboard (CYCLES_PER_SEC=4).
module tb_interval_countdown;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_timer = 1'b0;
  logic [3:0] value = 4'd0;
  logic       expired;
  logic       running;
  logic [3:0] remaining;
  logic       sec_tick;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_q[$];

  interval_countdown #(
    .CYCLES_PER_SEC(4),
    .VALUE_W(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_timer(start_timer),
    .value      (value),
    .expired    (expired),
    .running    (running),
    .remaining  (remaining),
    .sec_tick   (sec_tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle; settle, then check expired against the queue
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      chk("expired_due", {31'd0, expired}, 32'd1);
      void'(exp_q.pop_front());
    end else if (expired) begin
      chk("expired_spurious", {31'd0, expired}, 32'd0);
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_timer = 1'b0;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start(input logic [3:0] v);
    start_timer = 1'b1;
    value = v;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_expired", {31'd0, expired}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_remaining", {28'd0, remaining}, 32'd0);
    chk("rst_sec_tick", {31'd0, sec_tick}, 32'd0);

    // value=6: expired at 25, value change mid-run ignored
    cyc = 0;
    start(4'd6);
    exp_q.push_back(25);
    step();
    start_timer = 1'b0;
    value = 4'd3;
    for (int c = 1; c <= 24; c++) begin
      chk("t6_running", {31'd0, running}, 32'd1);
      chk("t6_remaining", {28'd0, remaining},
          32'(6 - (c - 1) / 4));
      chk("t6_sec_tick", {31'd0, sec_tick},
          32'((c >= 5) && ((c - 1) % 4 == 0)));
      step();
    end
    chk("t6_run_done", {31'd0, running}, 32'd0);
    chk("t6_rem_done", {28'd0, remaining}, 32'd0);
    chk("t6_last_tick", {31'd0, sec_tick}, 32'd1);
    step();
    chk("t6_idle_run", {31'd0, running}, 32'd0);
    chk("t6_idle_tick", {31'd0, sec_tick}, 32'd0);
    run_to(30);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    // value=0: expired in cycle 1, never running
    cyc = 0;
    start(4'd0);
    exp_q.push_back(1);
    step();
    start_timer = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("t0_running", {31'd0, running}, 32'd0);
      step();
    end
    chk("t0_drained", 32'(exp_q.size()), 32'd0);

    // value=15: full count without wrap, expired at 61
    cyc = 0;
    start(4'd15);
    exp_q.push_back(61);
    step();
    start_timer = 1'b0;
    chk("t15_rem_first", {28'd0, remaining}, 32'd15);
    run_to(60);
    chk("t15_running60", {31'd0, running}, 32'd1);
    chk("t15_rem60", {28'd0, remaining}, 32'd1);
    step();
    chk("t15_rem61", {28'd0, remaining}, 32'd0);
    chk("t15_running61", {31'd0, running}, 32'd0);
    run_to(66);
    chk("t15_drained", 32'(exp_q.size()), 32'd0);

    // value=8 restarted with value=2 at cycle 10: expired at 19
    cyc = 0;
    start(4'd8);
    exp_q.push_back(19);
    step();
    start_timer = 1'b0;
    run_to(10);
    start(4'd2);
    step();
    start_timer = 1'b0;
    chk("rs_rem11", {28'd0, remaining}, 32'd2);
    chk("rs_running11", {31'd0, running}, 32'd1);
    run_to(40);
    chk("rs_drained", 32'(exp_q.size()), 32'd0);

    // value=1, restart on the expiry edge: expired at 17 only
    cyc = 0;
    start(4'd1);
    exp_q.push_back(17);
    step();
    start_timer = 1'b0;
    run_to(4);
    start(4'd3);
    step();
    start_timer = 1'b0;
    chk("ee_running5", {31'd0, running}, 32'd1);
    chk("ee_rem5", {28'd0, remaining}, 32'd3);
    run_to(24);
    chk("ee_drained", 32'(exp_q.size()), 32'd0);

    // start while in DONE: pulse kept, new load follows
    cyc = 0;
    start(4'd1);
    exp_q.push_back(5);
    exp_q.push_back(10);
    step();
    start_timer = 1'b0;
    run_to(5);
    start(4'd1);
    step();
    start_timer = 1'b0;
    chk("dn_running6", {31'd0, running}, 32'd1);
    chk("dn_rem6", {28'd0, remaining}, 32'd1);
    run_to(14);
    chk("dn_drained", 32'(exp_q.size()), 32'd0);

    // value=10, reset at cycle 9 aborts with no pulse
    cyc = 0;
    start(4'd10);
    step();
    start_timer = 1'b0;
    run_to(9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 10; c <= 60; c++) begin
      chk("ab_running", {31'd0, running}, 32'd0);
      chk("ab_remaining", {28'd0, remaining}, 32'd0);
      chk("ab_sec_tick", {31'd0, sec_tick}, 32'd0);
      chk("ab_expired", {31'd0, expired}, 32'd0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
